seq_mul: RTL and testbench

- Parametrised sequential shift-add multiplier. Successor to the fixed 4-bit single-cycle multiplier.
- Computes a WIDTH x WIDTH product in 2*WIDTH bits, one multiplier bit per cycle.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Valid/ready handshake on both input and output. Sits between an operand producer and a result consumer that may stall.

---
 rtl/seq_mul.sv | 149 ++++++++++++++
 tb/tb_seq_mul.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, unsigned or two's complement.
// Latency: result valid WIDTH+1 edges after the accept edge; one operation in flight at a time.
// Backpressure: holds the result in DONE until out_ready (or abort); in_ready is low while not IDLE.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready operand handshake; a, b, signed_mode sampled on the accept edge
//   abort             synchronous cancel (drops an in-flight op or a pending result)
//   out_valid/out_ready result handshake; p holds the product, retained after consumption
//   busy              high while iterating or applying the sign
module seq_mul #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [PW-1:0]     acc_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PW-1:0]     p_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              in_ready_q;

    // Next-state helpers for the datapath
    logic [WIDTH-1:0]  a_mag_d;
    logic [WIDTH-1:0]  b_mag_d;
    logic              neg_d;
    logic [PW-1:0]     addend_d;
    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     p_d;

    // Magnitudes: the most negative operand negates to 2^(WIDTH-1), which is
    // exactly representable as an unsigned WIDTH-bit value.
    always_comb begin
        a_mag_d = (signed_mode && a[WIDTH-1]) ? WIDTH'(-a) : a;
        b_mag_d = (signed_mode && b[WIDTH-1]) ? WIDTH'(-b) : b;
        neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    // Partial product for the current multiplier bit, weighted by the iteration index.
    always_comb begin
        addend_d = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        acc_d    = mplier_q[0] ? (acc_q + addend_d) : acc_q;
        // Negating a zero accumulator yields zero, so no negative-zero case exists.
        p_d      = neg_q ? PW'(-acc_q) : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // abort blocks acceptance of operands presented on the same edge
                    if (in_valid && !abort) begin
                        mcand_q    <= a_mag_d;
                        mplier_q   <= b_mag_d;
                        neg_q      <= neg_d;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (abort) begin
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= SIGN;
                        end
                    end
                end
                SIGN: begin
                    busy_q <= 1'b0;
                    if (abort) begin
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        p_q         <= p_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // abort here simply discards the pending result
                    if (out_ready || abort) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_mul.sv
module tb_seq_mul;

    logic clk;
    logic rst;

    // WIDTH=8 instance
    logic        in_valid, in_ready, signed_mode, abort, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] p;

    // WIDTH=4 instance
    logic        in_valid4, in_ready4, sm4, abort4, out_valid4, out_ready4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    int checks = 0;
    int errors = 0;

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    seq_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .signed_mode(sm4), .abort(abort4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .p(p4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge with dut8 idle; returns 1 unit after the accept edge.
    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic sm);
        a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~av; b = 8'h5A; signed_mode = ~sm;   // latched values must be the ones used
    endtask

    // Counts rising edges after the accept edge until out_valid is seen.
    task automatic wait8(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full operation with out_ready high: latency, product, return to idle.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic sm, input logic [15:0] exp);
        int lat;
        start8(av, bv, sm);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_in_ready_lo"}, in_ready, 0);
        wait8(lat);
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_p"}, p, exp);
        @(posedge clk); #1;
        chk({tag, "_idle"}, in_ready, 1);
        chk({tag, "_ov_lo"}, out_valid, 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; signed_mode = 0; abort = 0; out_ready = 1;
        in_valid4 = 0; a4 = 0; b4 = 0; sm4 = 0; abort4 = 0; out_ready4 = 1;

        #12;
        chk("rst_p", p, 16'h0000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned maximum
        op8("u255x255", 8'd255, 8'd255, 1'b0, 16'hFE01);

        // Signed extremes
        op8("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
        op8("s_m128x127",  8'h80, 8'h7F, 1'b1, 16'hC080);
        op8("s_m1x1",      8'hFF, 8'h01, 1'b1, 16'hFFFF);
        op8("s_0xm5",      8'h00, 8'hFB, 1'b1, 16'h0000);
        op8("s_3xm7",      8'h03, 8'hF9, 1'b1, 16'hFFEB);
        op8("u200x3",      8'd200, 8'd3, 1'b0, 16'd600);

        // Backpressure: result held for 5 cycles, in_valid pulses ignored
        out_ready = 1'b0;
        start8(8'd10, 8'd20, 1'b0);
        wait8(lat);
        chk("bp_latency", lat, 9);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 8'd1; b = 8'd1;
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_p", p, 16'h00C8);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ov", out_valid, 0);
        chk("bp_release_idle", in_ready, 1);
        chk("bp_p_retained", p, 16'h00C8);

        // Abort during CALC
        start8(8'd7, 8'd9, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ov", out_valid, 0);
        chk("abort_p_kept", p, 16'h00C8);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort_ov_stays_lo", out_valid, 0);
        end
        op8("after_abort_7x9", 8'd7, 8'd9, 1'b0, 16'd63);

        // Abort in DONE drops the result
        out_ready = 1'b0;
        start8(8'd5, 8'd5, 1'b0);
        wait8(lat);
        chk("abort_done_p", p, 16'd25);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        out_ready = 1'b1;
        chk("abort_done_ov", out_valid, 0);
        chk("abort_done_idle", in_ready, 1);

        // Abort in IDLE wins over in_valid
        abort = 1'b1; in_valid = 1'b1; a = 8'd2; b = 8'd2;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_idle_noaccept_busy", busy, 0);
        chk("abort_idle_noaccept_rdy", in_ready, 1);

        // Reset mid-operation, together with abort
        start8(8'd100, 8'd3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1; abort = 1'b1;
        #1;
        chk("midrst_p", p, 16'h0000);
        chk("midrst_ov", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        op8("after_rst_12x12", 8'd12, 8'd12, 1'b0, 16'd144);

        // WIDTH=4 exhaustive, unsigned then signed
        for (int sm = 0; sm < 2; sm++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    int sx, sy, pr;
                    logic [7:0] e;
                    sx = (sm == 1 && x >= 8) ? x - 16 : x;
                    sy = (sm == 1 && y >= 8) ? y - 16 : y;
                    pr = sx * sy;
                    e = pr[7:0];
                    a4 = x[3:0]; b4 = y[3:0]; sm4 = sm[0]; in_valid4 = 1'b1;
                    @(posedge clk); #1;
                    in_valid4 = 1'b0;
                    lat = 0;
                    while (!out_valid4 && lat < 32) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    chk("w4_latency", lat, 5);
                    chk("w4_p", p4, e);
                    @(posedge clk); #1;
                end
            end
        end
        chk("w4_final_idle", in_ready4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
